// File: rtl/text_line_fetch.sv
// Text line fetcher: pulls one text line from the text RAM into the back
// buffer of a double-buffered line store. Characters are read out of the
// front buffer by column, one cycle after the column is applied.
module text_line_fetch #(
    parameter int COLUMNS = 80,
    parameter int LINES   = 30,
    parameter int CHAR_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      line_req,
    input  logic [7:0]                line_idx,
    input  logic                      swap,
    output logic [7:0]                rd_address,
    input  logic [COLUMNS*CHAR_W-1:0] rd_data,
    input  logic [6:0]                char_col,
    output logic [CHAR_W-1:0]         char_out,
    output logic                      busy,
    output logic                      fetch_done,
    output logic                      overrun
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StAddr  = 3'd1;
    localparam logic [2:0] StWait0 = 3'd2;
    localparam logic [2:0] StWait1 = 3'd3;
    localparam logic [2:0] StLatch = 3'd4;

    localparam logic [8:0] LinesLim = 9'(LINES);

    logic [2:0]                state_q, state_d;
    logic [7:0]                addr_q;
    logic                      zero_pend_q;
    logic                      fetch_done_q;
    logic                      overrun_q;
    logic                      front_q;
    logic [COLUMNS*CHAR_W-1:0] buf0_q, buf1_q;
    logic [CHAR_W-1:0]         char_q;

    logic                      idle, idx_ok, req_ok, req_oor, wr_en;
    logic [COLUMNS*CHAR_W-1:0] wr_line, front_line;
    logic [CHAR_W-1:0]         cell_d;

    assign idle    = (state_q == StIdle);
    assign idx_ok  = ({1'b0, line_idx} < LinesLim);
    assign req_ok  = line_req && idle && idx_ok;
    assign req_oor = line_req && idle && !idx_ok;

    // Out-of-range requests write a blank line one cycle later without a RAM access.
    assign wr_en   = (state_q == StLatch) || zero_pend_q;
    assign wr_line = (state_q == StLatch) ? rd_data : '0;

    // Next-state: fixed four-cycle walk covering the two-cycle RAM latency.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_ok) state_d = StAddr;
            StAddr:  state_d = StWait0;
            StWait0: state_d = StWait1;
            StWait1: state_d = StLatch;
            StLatch: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Control state, address hold, done pulse, sticky overrun and buffer select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            zero_pend_q  <= 1'b0;
            fetch_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            front_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            zero_pend_q  <= req_oor;
            fetch_done_q <= wr_en;
            front_q      <= front_q ^ swap;
            if (req_ok) begin
                addr_q <= line_idx;
            end
            // A swap landing on the LATCH edge is the intended hand-over, not a collision.
            if ((line_req && !idle) || (swap && !idle && state_q != StLatch)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Write the completed line into whichever buffer is back before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf0_q <= '0;
            buf1_q <= '0;
        end else if (wr_en) begin
            if (front_q) begin
                buf0_q <= wr_line;
            end else begin
                buf1_q <= wr_line;
            end
        end
    end

    // Column select from the front buffer; columns past the line read as zero.
    always_comb begin
        front_line = front_q ? buf1_q : buf0_q;
        cell_d     = '0;
        for (int i = 0; i < COLUMNS; i++) begin
            if (char_col == 7'(i)) begin
                cell_d = front_line[CHAR_W*i +: CHAR_W];
            end
        end
    end

    // Register the selected character.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_q <= '0;
        end else begin
            char_q <= cell_d;
        end
    end

    assign rd_address = addr_q;
    assign char_out   = char_q;
    assign busy       = !idle;
    assign fetch_done = fetch_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_text_line_fetch.sv
// Bench for text_line_fetch: directed scenarios, a line-buffer model checked
// on every falling edge, and literal spot checks that pin the model.
module tb_text_line_fetch;

    localparam int COLUMNS = 80;
    localparam int LINES   = 30;
    localparam int CHAR_W  = 16;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      line_req;
    logic [7:0]                line_idx;
    logic                      swap;
    logic [7:0]                rd_address;
    logic [COLUMNS*CHAR_W-1:0] rd_data;
    logic [6:0]                char_col;
    logic [CHAR_W-1:0]         char_out;
    logic                      busy;
    logic                      fetch_done;
    logic                      overrun;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    text_line_fetch #(
        .COLUMNS (COLUMNS),
        .LINES   (LINES),
        .CHAR_W  (CHAR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_req   (line_req),
        .line_idx   (line_idx),
        .swap       (swap),
        .rd_address (rd_address),
        .rd_data    (rd_data),
        .char_col   (char_col),
        .char_out   (char_out),
        .busy       (busy),
        .fetch_done (fetch_done),
        .overrun    (overrun)
    );

    // Text RAM contents: line 5 is 0x0741 everywhere, others {0x10+line, column}.
    function automatic logic [CHAR_W-1:0] ram_cell(input int idx, input int col);
        if (idx == 5) return 16'h0741;
        return {8'(8'h10 + idx), 8'(col)};
    endfunction

    // Text RAM with two cycles of read latency.
    logic [7:0] ram_a1 = '0;
    logic [7:0] ram_a2 = '0;
    always @(posedge clk) begin
        ram_a1 <= rd_address;
        ram_a2 <= ram_a1;
    end
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < COLUMNS; c++) rd_data[c*CHAR_W +: CHAR_W] = ram_cell(int'(ram_a2), c);
    end

    // Model: two line buffers, a front index, and countdowns to pending writes.
    logic [CHAR_W-1:0] m_buf [2][COLUMNS];
    int                m_front;
    int                m_busy_left;
    int                m_zero_left;
    int                m_idx;
    logic [7:0]        m_addr;
    logic [CHAR_W-1:0] m_char;
    logic              m_fd;
    logic              m_over;

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < COLUMNS; c++) m_buf[b][c] = '0;
        m_front = 0; m_busy_left = 0; m_zero_left = 0; m_idx = 0;
        m_addr = '0; m_char = '0; m_fd = 1'b0; m_over = 1'b0;
    endtask

    task automatic model_step();
        int                back;
        bit                was_busy;
        logic [CHAR_W-1:0] ch;
        back = 1 - m_front;
        ch = (int'(char_col) < COLUMNS) ? m_buf[m_front][int'(char_col)] : '0;
        m_fd = 1'b0;
        if (m_busy_left == 1) begin
            for (int c = 0; c < COLUMNS; c++) m_buf[back][c] = ram_cell(m_idx, c);
            m_fd = 1'b1;
        end
        if (m_zero_left == 1) begin
            for (int c = 0; c < COLUMNS; c++) m_buf[back][c] = '0;
            m_fd = 1'b1;
        end
        if (swap && m_busy_left > 1) m_over = 1'b1;
        was_busy = (m_busy_left > 0);
        if (m_busy_left > 0) m_busy_left--;
        if (m_zero_left > 0) m_zero_left--;
        if (line_req) begin
            if (was_busy) m_over = 1'b1;
            else if (int'(line_idx) < LINES) begin
                m_busy_left = 4; m_idx = int'(line_idx); m_addr = line_idx;
            end else m_zero_left = 1;
        end
        if (swap) m_front = back;
        m_char = ch;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("rd_address", 32'(rd_address), 32'(m_addr));
        chk("char_out",   32'(char_out),   32'(m_char));
        chk("busy",       32'(busy),       32'(m_busy_left > 0));
        chk("fetch_done", 32'(fetch_done), 32'(m_fd));
        chk("overrun",    32'(overrun),    32'(m_over));
    end

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic step(input logic lr, input logic [7:0] idx, input logic sw,
                        input logic [6:0] col);
        line_req = lr; line_idx = idx; swap = sw; char_col = col;
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
        line_req = 1'b0; swap = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; line_req = 1'b0; line_idx = '0; swap = 1'b0; char_col = '0;
        model_reset();
        repeat (3) step(1'b0, 8'd0, 1'b0, 7'd0);
        chk("lit_reset_busy", 32'(busy), 32'd0);
        chk("lit_reset_char", 32'(char_out), 32'd0);
        rst_n = 1'b1;

        // Basic fetch of line 5, accepted on the first edge after reset.
        step(1'b1, 8'd5, 1'b0, 7'd3);
        chk("lit_basic_addr0", 32'(rd_address), 32'd5);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 8'd0, 1'b0, 7'd3);
            chk("lit_basic_addr", 32'(rd_address), 32'd5);
            chk("lit_basic_done", 32'(fetch_done), 32'(k == 4));
        end
        step(1'b0, 8'd0, 1'b1, 7'd3);
        step(1'b0, 8'd0, 1'b0, 7'd3);
        chk("lit_basic_char", 32'(char_out), 32'h0741);

        // Column bounds on line 2.
        step(1'b1, 8'd2, 1'b0, 7'd0);
        repeat (4) step(1'b0, 8'd0, 1'b0, 7'd0);
        step(1'b0, 8'd0, 1'b1, 7'd0);
        step(1'b0, 8'd0, 1'b0, 7'd0);
        chk("lit_col0", 32'(char_out), 32'h1200);
        step(1'b0, 8'd0, 1'b0, 7'd79);
        chk("lit_col79", 32'(char_out), 32'h124F);
        step(1'b0, 8'd0, 1'b0, 7'd80);
        chk("lit_col80", 32'(char_out), 32'd0);
        step(1'b0, 8'd0, 1'b0, 7'd127);
        chk("lit_col127", 32'(char_out), 32'd0);

        // Swap on the LATCH edge: new line visible immediately, no overrun.
        step(1'b1, 8'd3, 1'b0, 7'd5);
        repeat (3) step(1'b0, 8'd0, 1'b0, 7'd5);
        step(1'b0, 8'd0, 1'b1, 7'd5);
        step(1'b0, 8'd0, 1'b0, 7'd5);
        chk("lit_latch_swap_char", 32'(char_out), 32'h1305);
        chk("lit_latch_swap_ovr", 32'(overrun), 32'd0);

        // Out-of-range line: blank line one cycle later, no address change.
        step(1'b1, 8'd30, 1'b0, 7'd0);
        chk("lit_oor_addr", 32'(rd_address), 32'd3);
        chk("lit_oor_busy", 32'(busy), 32'd0);
        chk("lit_oor_done0", 32'(fetch_done), 32'd0);
        step(1'b0, 8'd0, 1'b0, 7'd0);
        chk("lit_oor_done1", 32'(fetch_done), 32'd1);
        step(1'b0, 8'd0, 1'b1, 7'd0);
        for (int c = 0; c < 128; c += 9) step(1'b0, 8'd0, 1'b0, 7'(c));
        step(1'b0, 8'd0, 1'b0, 7'd40);
        chk("lit_oor_char", 32'(char_out), 32'd0);

        // Second request two cycles into a fetch is dropped.
        step(1'b1, 8'd7, 1'b0, 7'd0);
        step(1'b0, 8'd0, 1'b0, 7'd0);
        step(1'b1, 8'd9, 1'b0, 7'd0);
        chk("lit_ovr_flag", 32'(overrun), 32'd1);
        chk("lit_ovr_addr", 32'(rd_address), 32'd7);
        step(1'b0, 8'd0, 1'b0, 7'd0);
        chk("lit_ovr_done_early", 32'(fetch_done), 32'd0);
        step(1'b0, 8'd0, 1'b0, 7'd0);
        chk("lit_ovr_done", 32'(fetch_done), 32'd1);
        step(1'b0, 8'd0, 1'b0, 7'd0);
        chk("lit_ovr_done_once", 32'(fetch_done), 32'd0);

        // Reset asserted while in WAIT1.
        step(1'b1, 8'd6, 1'b0, 7'd1);
        step(1'b0, 8'd0, 1'b0, 7'd1);
        step(1'b0, 8'd0, 1'b0, 7'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("lit_rst_busy", 32'(busy), 32'd0);
        chk("lit_rst_char", 32'(char_out), 32'd0);
        chk("lit_rst_ovr", 32'(overrun), 32'd0);
        repeat (2) begin
            step(1'b0, 8'd0, 1'b0, 7'd1);
            chk("lit_rst_done", 32'(fetch_done), 32'd0);
        end
        rst_n = 1'b1;
        step(1'b1, 8'd6, 1'b0, 7'd1);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 8'd0, 1'b0, 7'd1);
            chk("lit_after_rst_done", 32'(fetch_done), 32'(k == 4));
        end

        // Swap during WAIT0: overrun, data lands in the new back buffer.
        step(1'b1, 8'd4, 1'b0, 7'd1);
        step(1'b0, 8'd0, 1'b0, 7'd1);
        step(1'b0, 8'd0, 1'b1, 7'd1);
        chk("lit_wait0_ovr", 32'(overrun), 32'd1);
        step(1'b0, 8'd0, 1'b0, 7'd1);
        step(1'b0, 8'd0, 1'b0, 7'd1);
        chk("lit_wait0_done", 32'(fetch_done), 32'd1);
        step(1'b0, 8'd0, 1'b0, 7'd1);
        chk("lit_wait0_front", 32'(char_out), 32'h1601);
        step(1'b0, 8'd0, 1'b1, 7'd1);
        step(1'b0, 8'd0, 1'b0, 7'd1);
        chk("lit_wait0_back", 32'(char_out), 32'h1401);

        repeat (2) step(1'b0, 8'd0, 1'b0, 7'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/text_line_fetch.md
TEXT_LINE_FETCH -- requirements
Module: text_line_fetch

Interface
REQ-001 Parameter COLUMNS, default 80: characters per text line.
REQ-002 Parameter LINES, default 30: text lines held in text RAM.
REQ-003 Parameter CHAR_W, default 16: bits per character cell (8 attribute, 8 code).
REQ-004 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port line_req, input, 1: one-cycle pulse requesting a fetch of line_idx into the back buffer.
REQ-007 Port line_idx, input, 8: text line to fetch; sampled only when line_req=1.
REQ-008 Port swap, input, 1: one-cycle pulse exchanging the front and back buffers at the display line boundary.
REQ-009 Port rd_address, output, 8: text RAM read-port address.
REQ-010 Port rd_data, input, COLUMNS*CHAR_W: text RAM read data, valid two cycles after rd_address is presented.
REQ-011 Port char_col, input, 7: column read from the front buffer.
REQ-012 Port char_out, output, CHAR_W: registered cell of the front buffer at char_col.
REQ-013 Port busy, output, 1: high while a fetch is in progress.
REQ-014 Port fetch_done, output, 1: one-cycle pulse when a fetched line is written into a buffer.
REQ-015 Port overrun, output, 1: sticky flag for a dropped line_req or a swap during a fetch.

Function
REQ-016 The FSM SHALL have states IDLE, ADDR, WAIT0, WAIT1, LATCH; reset state is IDLE.
REQ-017 IDLE with line_req=1 and line_idx<LINES: latch line_idx, go to ADDR, drive rd_address=line_idx.
REQ-018 ADDR->WAIT0->WAIT1->LATCH, one state per cycle, unconditionally.
REQ-019 rd_address SHALL hold the latched index from ADDR through LATCH.
REQ-020 LATCH: write rd_data into the buffer that is back before the edge, pulse fetch_done, then go to IDLE.
REQ-021 Latency: fetch_done SHALL assert exactly 4 cycles after the edge that samples line_req.
REQ-022 IDLE with line_req=1 and line_idx>=LINES: no RAM access; next cycle write an all-zero line into the back buffer and pulse fetch_done (latency 1).
REQ-023 busy=1 in ADDR, WAIT0, WAIT1, LATCH; else 0.
REQ-024 line_req while busy=1 SHALL be dropped, set overrun, and leave the fetch in progress unaffected.
REQ-025 swap SHALL toggle the front/back select every time it occurs, regardless of FSM state.
REQ-026 swap while busy=1 and not in LATCH SHALL set overrun; the fetch completes into the buffer that is back at LATCH.
REQ-027 swap in the LATCH cycle: the just-written buffer becomes front after that edge; no overrun.
REQ-028 char_out SHALL equal front-buffer cell char_col, registered one cycle (the value on the edge after char_col is applied).
REQ-029 char_col>=COLUMNS SHALL give char_out=0.
REQ-030 Cell i SHALL occupy rd_data bits [CHAR_W*i +: CHAR_W], with cell 0 at the LSBs.
REQ-031 overrun SHALL clear only on reset.

Reset
REQ-032 While rst_n=0: FSM=IDLE, rd_address=0, char_out=0, busy=0, fetch_done=0, overrun=0, both buffers all-zero, buffer 0 front.
REQ-033 Reset asserted mid-fetch SHALL abort the fetch with no buffer write and no fetch_done.
REQ-034 After rst_n deasserts, line_req is accepted on the first rising edge.

Verification
REQ-035 Basic fetch: RAM line 5 = 0x0741 in every cell; line_req, line_idx=5 at t0 -> rd_address=5 t0+1..t0+4, fetch_done at t0+4; then swap, char_col=3 -> char_out=0x0741 one cycle later.
REQ-036 Out-of-range: line_idx=30 -> no rd_address change, fetch_done next cycle; after swap every char_col gives char_out=0.
REQ-037 Overrun: second line_req 2 cycles into a fetch -> dropped, overrun=1, first fetch_done timing unchanged.
REQ-038 Swap collisions: swap in WAIT0 -> overrun=1, data lands in the new back buffer; swap in LATCH -> new data visible on char_out with no overrun.
REQ-039 Reset mid-fetch: rst_n low in WAIT1 -> no fetch_done, char_out=0, busy=0; the next fetch completes normally.
REQ-040 Column bounds: char_col=0, 79, 80, 127 -> cells 0 and 79 correct; 80 and 127 give 0.
